// File: rtl/uart_pkg.sv
// Shared constants for the uart byte-buffering slice.
//   UART_DW      : uart character width in bits
//   ERRCNT_W     : width of the saturating framing-error counter
//   UART_FIFO_AW : default log2 depth of the TX/RX FIFOs
package uart_pkg;

   localparam int UART_DW      = 8;
   localparam int ERRCNT_W     = 8;
   localparam int UART_FIFO_AW = 4;

   typedef logic [UART_DW-1:0] uart_byte_t;

   localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register-array storage and fall-through read port.
// Ports:
//   CLK_I, RESET_N_I : clock, async active-low reset (empties the FIFO)
//   push, din        : write din at the tail; ignored while full
//   pop              : drop the head; ignored while empty
//   dout             : current head, 0 while empty
//   full, empty      : occupancy flags
//   level            : occupancy, 0..2**AW
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DW = UART_DW,
   parameter int AW = UART_FIFO_AW
) (
   input  logic          CLK_I,
   input  logic          RESET_N_I,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam int DEPTH = 2**AW;

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [DW-1:0] mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   // The extra pointer bit separates full from empty when the index bits match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   // Full is judged before any same-cycle pop, so a pop never makes room for a push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign level   = wr_ptr - rd_ptr;
   // Storage is not reset; masking with empty keeps stale bytes invisible.
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK_I or negedge RESET_N_I) begin
      if (!RESET_N_I) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_fifo.sv
// Byte buffering between the bus glue and the uart core.
// Ports:
//   CLK_I, RESET_N_I          : clock, async active-low reset
//   WR_DATA_I/WR_VALID_I/WR_READY_O : bus-side push into the TX FIFO
//   UTX_DATA_O/UTX_VALID_O/UTX_BUSY_I : TX FIFO head towards the uart transmitter
//   URX_DATA_I/URX_VALID_I    : received byte strobe from the uart
//   URX_ERROR_I               : framing-error strobe from the uart
//   RD_DATA_O/RD_VALID_O/RD_I : fall-through RX FIFO head and pop
//   TX_LEVEL_O/RX_LEVEL_O     : FIFO occupancies
//   RX_OVERRUN_O              : sticky, an RX byte was dropped on a full FIFO
//   RX_ERRCNT_O               : saturating framing-error count
//   CLR_I                     : clears overrun flag and error count
module uart_fifo
   import uart_pkg::*;
#(
   parameter int AW = UART_FIFO_AW
) (
   input  logic                CLK_I,
   input  logic                RESET_N_I,
   input  logic [UART_DW-1:0]  WR_DATA_I,
   input  logic                WR_VALID_I,
   output logic                WR_READY_O,
   output logic [UART_DW-1:0]  UTX_DATA_O,
   output logic                UTX_VALID_O,
   input  logic                UTX_BUSY_I,
   input  logic [UART_DW-1:0]  URX_DATA_I,
   input  logic                URX_VALID_I,
   input  logic                URX_ERROR_I,
   output logic [UART_DW-1:0]  RD_DATA_O,
   output logic                RD_VALID_O,
   input  logic                RD_I,
   output logic [AW:0]         TX_LEVEL_O,
   output logic [AW:0]         RX_LEVEL_O,
   output logic                RX_OVERRUN_O,
   output logic [ERRCNT_W-1:0] RX_ERRCNT_O,
   input  logic                CLR_I
);

   logic tx_full;
   logic tx_empty;
   logic tx_push;
   logic tx_pop;
   logic rx_full;
   logic rx_empty;
   logic rx_pop;

   assign WR_READY_O  = !tx_full;
   assign UTX_VALID_O = !tx_empty;
   assign RD_VALID_O  = !rx_empty;

   assign tx_push = WR_VALID_I && !tx_full;
   // The uart latches the head on this edge and raises busy from it.
   assign tx_pop  = !tx_empty && !UTX_BUSY_I;
   assign rx_pop  = RD_I && !rx_empty;

   sync_fifo #(.DW(UART_DW), .AW(AW)) u_tx_fifo (
      .CLK_I     (CLK_I),
      .RESET_N_I (RESET_N_I),
      .push      (tx_push),
      .pop       (tx_pop),
      .din       (WR_DATA_I),
      .dout      (UTX_DATA_O),
      .full      (tx_full),
      .empty     (tx_empty),
      .level     (TX_LEVEL_O)
   );

   sync_fifo #(.DW(UART_DW), .AW(AW)) u_rx_fifo (
      .CLK_I     (CLK_I),
      .RESET_N_I (RESET_N_I),
      .push      (URX_VALID_I),
      .pop       (rx_pop),
      .din       (URX_DATA_I),
      .dout      (RD_DATA_O),
      .full      (rx_full),
      .empty     (rx_empty),
      .level     (RX_LEVEL_O)
   );

   // A new overrun or error event takes priority over a coincident clear.
   always_ff @(posedge CLK_I or negedge RESET_N_I) begin
      if (!RESET_N_I) begin
         RX_OVERRUN_O <= 1'b0;
      end else if (URX_VALID_I && rx_full) begin
         RX_OVERRUN_O <= 1'b1;
      end else if (CLR_I) begin
         RX_OVERRUN_O <= 1'b0;
      end
   end

   always_ff @(posedge CLK_I or negedge RESET_N_I) begin
      if (!RESET_N_I) begin
         RX_ERRCNT_O <= '0;
      end else if (URX_ERROR_I) begin
         if (CLR_I)
            RX_ERRCNT_O <= {{(ERRCNT_W-1){1'b0}}, 1'b1};
         else if (RX_ERRCNT_O != ERRCNT_MAX)
            RX_ERRCNT_O <= RX_ERRCNT_O + 1'b1;
      end else if (CLR_I) begin
         RX_ERRCNT_O <= '0;
      end
   end

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  utx_data;
   logic        utx_valid;
   logic        utx_busy;
   logic [7:0]  urx_data;
   logic        urx_valid;
   logic        urx_error;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd;
   logic [AW:0] tx_level;
   logic [AW:0] rx_level;
   logic        rx_overrun;
   logic [7:0]  rx_errcnt;
   logic        clr;

   always #5 clk = ~clk;

   uart_fifo #(.AW(AW)) dut (
      .CLK_I        (clk),
      .RESET_N_I    (rst_n),
      .WR_DATA_I    (wr_data),
      .WR_VALID_I   (wr_valid),
      .WR_READY_O   (wr_ready),
      .UTX_DATA_O   (utx_data),
      .UTX_VALID_O  (utx_valid),
      .UTX_BUSY_I   (utx_busy),
      .URX_DATA_I   (urx_data),
      .URX_VALID_I  (urx_valid),
      .URX_ERROR_I  (urx_error),
      .RD_DATA_O    (rd_data),
      .RD_VALID_O   (rd_valid),
      .RD_I         (rd),
      .TX_LEVEL_O   (tx_level),
      .RX_LEVEL_O   (rx_level),
      .RX_OVERRUN_O (rx_overrun),
      .RX_ERRCNT_O  (rx_errcnt),
      .CLR_I        (clr)
   );

   // Reference model: byte queues plus flag/counter
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic [7:0] tx_seen[$];
   logic [7:0] rx_seen[$];
   int         tx_lvl_seen[$];
   bit         m_ovr;
   int         m_err;
   bit         auto_busy;
   int         busy_cnt;
   int         n_checks;
   int         n_pass;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic compare_all();
      chk("wr_ready",   32'(wr_ready),   32'(txq.size() != DEPTH));
      chk("utx_valid",  32'(utx_valid),  32'(txq.size() != 0));
      chk("utx_data",   32'(utx_data),   (txq.size() != 0) ? 32'(txq[0]) : 32'd0);
      chk("rd_valid",   32'(rd_valid),   32'(rxq.size() != 0));
      chk("rd_data",    32'(rd_data),    (rxq.size() != 0) ? 32'(rxq[0]) : 32'd0);
      chk("tx_level",   32'(tx_level),   32'(txq.size()));
      chk("rx_level",   32'(rx_level),   32'(rxq.size()));
      chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
      chk("rx_errcnt",  32'(rx_errcnt),  32'(m_err));
   endtask

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      m_ovr    = 1'b0;
      m_err    = 0;
      busy_cnt = 0;
   endtask

   // One clock: model decisions from pre-edge inputs, then check after the edge.
   task automatic step();
      bit         tpop, tpush, rpop, rpush, ovf;
      logic [7:0] wd, ud;
      bit         er, cl;
      tpop  = (txq.size() != 0) && !utx_busy;
      tpush = wr_valid && (txq.size() < DEPTH);
      rpop  = rd && (rxq.size() != 0);
      rpush = urx_valid && (rxq.size() < DEPTH);
      ovf   = urx_valid && (rxq.size() == DEPTH);
      wd = wr_data; ud = urx_data; er = urx_error; cl = clr;
      if (tpop) tx_seen.push_back(utx_data);
      if (rpop) rx_seen.push_back(rd_data);
      @(posedge clk);
      if (tpop)  txq.delete(0);
      if (tpush) txq.push_back(wd);
      if (rpop)  rxq.delete(0);
      if (rpush) rxq.push_back(ud);
      if (ovf)     m_ovr = 1'b1;
      else if (cl) m_ovr = 1'b0;
      if (er)      m_err = cl ? 1 : ((m_err < 255) ? m_err + 1 : 255);
      else if (cl) m_err = 0;
      #1;
      wr_valid = 1'b0; urx_valid = 1'b0; urx_error = 1'b0; rd = 1'b0; clr = 1'b0;
      compare_all();
      if (tpop) tx_lvl_seen.push_back(int'(tx_level));
      if (auto_busy) begin
         if (tpop)              busy_cnt = 10;
         else if (busy_cnt > 0) busy_cnt--;
         utx_busy = (busy_cnt > 0);
      end
   endtask

   initial begin
      logic [7:0] drain_bytes [3];
      int         exp_lvl;
      n_checks = 0; n_pass = 0;
      auto_busy = 1'b0;
      rst_n = 1'b0;
      wr_data = '0; wr_valid = 1'b0; utx_busy = 1'b0;
      urx_data = '0; urx_valid = 1'b0; urx_error = 1'b0; rd = 1'b0; clr = 1'b0;
      model_reset();
      tx_seen.delete(); rx_seen.delete(); tx_lvl_seen.delete();

      // reset state
      #3;
      compare_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) step();

      // TX drain with busy model
      drain_bytes[0] = 8'h55; drain_bytes[1] = 8'hA3; drain_bytes[2] = 8'h0F;
      utx_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = drain_bytes[i]; wr_valid = 1'b1; step();
      end
      chk("drain_lvl3", 32'(tx_level), 32'd3);
      tx_seen.delete(); tx_lvl_seen.delete();
      auto_busy = 1'b1; busy_cnt = 0; utx_busy = 1'b0;
      repeat (40) step();
      auto_busy = 1'b0; utx_busy = 1'b0;
      chk("drain_cnt", 32'(tx_seen.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         exp_lvl = 2 - i;
         if (i < tx_seen.size()) chk("drain_data", 32'(tx_seen[i]), 32'(drain_bytes[i]));
         if (i < tx_lvl_seen.size()) chk("drain_lvl", 32'(tx_lvl_seen[i]), 32'(exp_lvl));
      end

      // TX full
      utx_busy = 1'b1;
      tx_seen.delete();
      for (int i = 0; i < 17; i++) begin
         wr_data = 8'(i); wr_valid = 1'b1; step();
         if (i == 15) begin
            chk("txfull_ready", 32'(wr_ready), 32'd0);
            chk("txfull_lvl16", 32'(tx_level), 32'd16);
         end
      end
      chk("txfull_lvl17", 32'(tx_level), 32'd16);
      auto_busy = 1'b1; busy_cnt = 0; utx_busy = 1'b0;
      repeat (200) step();
      auto_busy = 1'b0; utx_busy = 1'b0;
      chk("txfull_cnt", 32'(tx_seen.size()), 32'd16);
      for (int i = 0; i < 16; i++)
         if (i < tx_seen.size()) chk("txfull_data", 32'(tx_seen[i]), 32'(i));

      // RX overrun
      for (int i = 0; i < 17; i++) begin
         urx_data = 8'(8'hC0 + i); urx_valid = 1'b1; step();
      end
      chk("ovr_lvl", 32'(rx_level), 32'd16);
      chk("ovr_flag", 32'(rx_overrun), 32'd1);
      rx_seen.delete();
      repeat (17) begin
         rd = 1'b1; step();
      end
      chk("ovr_cnt", 32'(rx_seen.size()), 32'd16);
      for (int i = 0; i < 16; i++)
         if (i < rx_seen.size()) chk("ovr_data", 32'(rx_seen[i]), 32'(8'hC0 + i));
      clr = 1'b1; step();
      chk("ovr_clr", 32'(rx_overrun), 32'd0);

      // framing errors
      repeat (260) begin
         urx_error = 1'b1; step();
      end
      chk("err_sat", 32'(rx_errcnt), 32'd255);
      urx_error = 1'b1; clr = 1'b1; step();
      chk("err_clr_win", 32'(rx_errcnt), 32'd1);

      // randomized traffic
      repeat (3000) begin
         wr_data   = 8'($urandom);
         wr_valid  = ($urandom_range(0, 1) == 1);
         utx_busy  = ($urandom_range(0, 9) < 6);
         urx_data  = 8'($urandom);
         urx_valid = ($urandom_range(0, 1) == 1);
         rd        = ($urandom_range(0, 9) < 3);
         urx_error = ($urandom_range(0, 19) == 0);
         clr       = ($urandom_range(0, 29) == 0);
         step();
      end

      // async reset mid-transfer
      utx_busy = 1'b0;
      repeat (20) begin
         rd = 1'b1; step();
      end
      utx_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(8'h30 + i); wr_valid = 1'b1; step();
      end
      for (int i = 0; i < 3; i++) begin
         urx_data = 8'(8'h90 + i); urx_valid = 1'b1; step();
      end
      urx_error = 1'b1; step();
      chk("rst_pre_tx", 32'(tx_level), 32'd5);
      chk("rst_pre_rx", 32'(rx_level), 32'd3);
      rst_n = 1'b0;
      #2;
      model_reset();
      compare_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
      utx_busy = 1'b0;
      wr_data = 8'h7E; wr_valid = 1'b1; step();
      chk("post_rst_valid", 32'(utx_valid), 32'd1);
      chk("post_rst_data", 32'(utx_data), 32'h7E);
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
